// File: rtl/vga_panel_scheduler.sv
// vga_panel_scheduler: shares the single VGA pixel-write port among the
// volume (0), pitch (1) and distortion (2) effect panels. Each redraw request
// queues a job that draws the panel's on/off box (17x7) and then its 16-pixel
// level bar, one pixel per cycle. Pending requests are served round-robin.
// Optional build macro VGA_SCHED_CLEAR_EN: after reset the whole 160x120
// frame is cleared to OFF_COLOUR and then all three panels are redrawn.
module vga_panel_scheduler #(
    parameter logic [7:0]  X_BASE      = 8'd25,
    parameter logic [7:0]  PANEL_PITCH = 8'd40,
    parameter logic [11:0] ON_COLOUR   = 12'h9d5,
    parameter logic [11:0] BAR_COLOUR  = 12'ha35,
    parameter logic [11:0] OFF_COLOUR  = 12'h000
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        VolumeGo,
    input  logic        PitchGo,
    input  logic        DistortionGo,
    input  logic        VolumeOn,
    input  logic        PitchOn,
    input  logic        DistortionOn,
    input  logic [6:0]  volume_data,
    input  logic [6:0]  pitch_data,
    input  logic [6:0]  distortion_data,
    output logic [7:0]  x,
    output logic [6:0]  y,
    output logic [11:0] colour,
    output logic        writeEn,
    output logic        Busy,
    output logic [2:0]  DrawDone
);

    localparam logic [6:0] BOX_Y_TOP  = 7'd21;
    localparam logic [6:0] BOX_Y_BOT  = 7'd27;
    localparam logic [6:0] BAR_Y_BOT  = 7'd51;
    localparam logic [6:0] BAR_Y_TOP  = 7'd36;
    localparam logic [7:0] BOX_W_LAST = 8'd16;
    localparam logic [7:0] BAR_X_OFF  = 8'd8;
`ifdef VGA_SCHED_CLEAR_EN
    localparam logic [7:0] CLR_X_LAST = 8'd159;
    localparam logic [6:0] CLR_Y_LAST = 7'd119;
`endif

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_BOX   = 3'd1,
        S_BAR   = 3'd2,
        S_DONE  = 3'd3,
        S_CLEAR = 3'd4
    } state_t;

    state_t      state_r;
    logic [2:0]  pending_r;
    logic [1:0]  rr_ptr_r;
    logic [1:0]  grant_r;
    logic        on_r;
    logic [3:0]  height_r;
    logic [7:0]  x0_r;
    logic [7:0]  cx_r;
    logic [6:0]  cy_r;

    logic [2:0]  go_s;
    logic [1:0]  grant_idx_s;
    logic [2:0]  pend_clr_s;
    logic        grant_on_s;
    logic [6:0]  grant_level_s;
    logic [7:0]  grant_x0_s;
    logic [6:0]  bar_row_s;
    logic        bar_lit_s;

    // First requesting panel at or after ptr, wrapping modulo 3.
    function automatic logic [1:0] pick_next(input logic [2:0] req, input logic [1:0] ptr);
        logic [2:0] idx;
        logic [1:0] sel;
        sel = ptr;
        for (int k = 2; k >= 0; k--) begin
            idx = {1'b0, ptr} + 3'(k);
            if (idx >= 3'd3) begin
                idx = idx - 3'd3;
            end else begin
                idx = idx;
            end
            if (req[idx[1:0]]) begin
                sel = idx[1:0];
            end else begin
                sel = sel;
            end
        end
        return sel;
    endfunction

    // Panel index that follows g in round-robin order.
    function automatic logic [1:0] next_ptr(input logic [1:0] g);
        logic [1:0] n;
        case (g)
            2'd0:    n = 2'd1;
            2'd1:    n = 2'd2;
            default: n = 2'd0;
        endcase
        return n;
    endfunction

    // Arbitration, grant-time snapshot selection and bar lit/unlit decision.
    always_comb begin
        go_s        = {DistortionGo, PitchGo, VolumeGo};
        grant_idx_s = pick_next(pending_r, rr_ptr_r);
        if ((state_r == S_IDLE) && (pending_r != 3'b000)) begin
            pend_clr_s = 3'b001 << grant_idx_s;
        end else begin
            pend_clr_s = 3'b000;
        end
        case (grant_idx_s)
            2'd1: begin
                grant_on_s    = PitchOn;
                grant_level_s = pitch_data;
                grant_x0_s    = X_BASE + PANEL_PITCH;
            end
            2'd2: begin
                grant_on_s    = DistortionOn;
                grant_level_s = distortion_data;
                grant_x0_s    = X_BASE + PANEL_PITCH + PANEL_PITCH;
            end
            default: begin
                grant_on_s    = VolumeOn;
                grant_level_s = volume_data;
                grant_x0_s    = X_BASE;
            end
        endcase
        bar_row_s = BAR_Y_BOT - cy_r;
        bar_lit_s = (bar_row_s < {3'b000, height_r});
    end

    // Job sequencer: pending capture, grant, pixel emission and done pulse.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
`ifdef VGA_SCHED_CLEAR_EN
            state_r <= S_CLEAR;
`else
            state_r <= S_IDLE;
`endif
            pending_r <= 3'b000;
            rr_ptr_r  <= 2'd0;
            grant_r   <= 2'd0;
            on_r      <= 1'b0;
            height_r  <= 4'd0;
            x0_r      <= 8'd0;
            cx_r      <= 8'd0;
            cy_r      <= 7'd0;
            x         <= 8'd0;
            y         <= 7'd0;
            colour    <= 12'h000;
            writeEn   <= 1'b0;
            Busy      <= 1'b0;
            DrawDone  <= 3'b000;
        end else begin
            // A Go on the granted panel in the grant cycle re-queues it.
            pending_r <= (pending_r & ~pend_clr_s) | go_s;
            DrawDone  <= 3'b000;
            case (state_r)
                S_IDLE: begin
                    writeEn <= 1'b0;
                    if (pending_r != 3'b000) begin
                        grant_r  <= grant_idx_s;
                        on_r     <= grant_on_s;
                        height_r <= grant_level_s[6:3];
                        x0_r     <= grant_x0_s;
                        cx_r     <= grant_x0_s;
                        cy_r     <= BOX_Y_TOP;
                        Busy     <= 1'b1;
                        state_r  <= S_BOX;
                    end else begin
                        Busy <= 1'b0;
                    end
                end
                S_BOX: begin
                    x       <= cx_r;
                    y       <= cy_r;
                    colour  <= on_r ? ON_COLOUR : OFF_COLOUR;
                    writeEn <= 1'b1;
                    if (cx_r == (x0_r + BOX_W_LAST)) begin
                        if (cy_r == BOX_Y_BOT) begin
                            cx_r    <= x0_r + BAR_X_OFF;
                            cy_r    <= BAR_Y_BOT;
                            state_r <= S_BAR;
                        end else begin
                            cx_r <= x0_r;
                            cy_r <= cy_r + 7'd1;
                        end
                    end else begin
                        cx_r <= cx_r + 8'd1;
                    end
                end
                S_BAR: begin
                    x       <= cx_r;
                    y       <= cy_r;
                    colour  <= bar_lit_s ? BAR_COLOUR : OFF_COLOUR;
                    writeEn <= 1'b1;
                    if (cy_r == BAR_Y_TOP) begin
                        state_r <= S_DONE;
                    end else begin
                        cy_r <= cy_r - 7'd1;
                    end
                end
                S_DONE: begin
                    writeEn  <= 1'b0;
                    Busy     <= 1'b0;
                    DrawDone <= 3'b001 << grant_r;
                    rr_ptr_r <= next_ptr(grant_r);
                    state_r  <= S_IDLE;
                end
`ifdef VGA_SCHED_CLEAR_EN
                S_CLEAR: begin
                    x       <= cx_r;
                    y       <= cy_r;
                    colour  <= OFF_COLOUR;
                    writeEn <= 1'b1;
                    Busy    <= 1'b1;
                    if (cx_r == CLR_X_LAST) begin
                        cx_r <= 8'd0;
                        if (cy_r == CLR_Y_LAST) begin
                            pending_r <= 3'b111;
                            state_r   <= S_IDLE;
                        end else begin
                            cy_r <= cy_r + 7'd1;
                        end
                    end else begin
                        cx_r <= cx_r + 8'd1;
                    end
                end
`endif
                default: begin
                    writeEn <= 1'b0;
                    Busy    <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/vga_panel_scheduler.md
Name: vga_panel_scheduler

Overview:
- Sequences the single VGA pixel-write port among three effect panels: volume (0), pitch (1) and distortion (2).
- Each redraw request queues a job for its panel. A job draws the on/off indicator box, then the level bar, at one pixel per cycle.
- Requests are served round-robin. The block sits between the effect control logic and the vga_adapter x/y/colour/plot inputs.

Parameters:
- X_BASE, 25, x of panel 0 box left edge
- PANEL_PITCH, 40, x offset between consecutive panels
- ON_COLOUR, 12'h9d5, box colour when effect enabled
- BAR_COLOUR, 12'ha35, lit bar segment colour
- OFF_COLOUR, 12'h000, box-off and unlit bar colour

Ports:
- Clock  input  1  system clock, all logic on rising edge
- Reset  input  1  synchronous, active-low (0 = reset)
- VolumeGo  input  1  redraw request, panel 0, sampled each cycle
- PitchGo  input  1  redraw request, panel 1
- DistortionGo  input  1  redraw request, panel 2
- VolumeOn  input  1  panel 0 enable state
- PitchOn  input  1  panel 1 enable state
- DistortionOn  input  1  panel 2 enable state
- volume_data  input  7  panel 0 level, 0..127
- pitch_data  input  7  panel 1 level
- distortion_data  input  7  panel 2 level
- x  output  8  pixel column
- y  output  7  pixel row
- colour  output  12  pixel colour
- writeEn  output  1  pixel valid strobe to vga_adapter
- Busy  output  1  job in progress
- DrawDone  output  3  one-cycle done pulse, one bit per panel

Behaviour:
- Reset (Reset=0 at edge):
  - x, y, colour, writeEn, Busy and DrawDone are 0.
  - Pending[2:0] is 0, the round-robin pointer is 0, and the FSM is IDLE.
- Pending:
  - A Go high at edge k sets pending[i] at k+1.
  - Go is level-tolerant: holding Go high re-sets pending every cycle.
- States: IDLE, BOX, BAR, DONE.
- IDLE:
  - When pending is non-zero, grant the first set bit searching from rr_ptr upward, modulo 3.
  - Clear that pending bit and snapshot its On flag and level into internal registers.
  - Load the box counters and go to BOX. Busy goes to 1.
- BOX:
  - Emits 119 pixels, row-major: y=21..27 outer, x=X0..X0+16 inner, where X0 = X_BASE + g*PANEL_PITCH.
  - Colour is ON_COLOUR if the snapshot On=1, else OFF_COLOUR. writeEn=1 on every BOX/BAR cycle.
- BAR:
  - Emits 16 pixels at x=X0+8, y=51 down to 36.
  - Row index r = 51-y (0..15). Height h = level[6:3].
  - Colour is BAR_COLOUR if r < h, else OFF_COLOUR.
- DONE: one cycle.
  - writeEn=0 and DrawDone[g]=1.
  - rr_ptr is set to (g+1) mod 3, Busy drops to 0, and the FSM returns to IDLE.
- Latency and timing:
  - The first pixel is on the outputs 2 cycles after the Go edge (one cycle to pending, one cycle for the IDLE grant).
  - A job is 135 consecutive writeEn cycles. Back-to-back jobs have a 2-cycle gap (DONE, IDLE).
- Input snapshot: On and level are sampled only at grant; input changes mid-job do not affect that job.
- Go for the panel currently drawing re-sets its pending bit, so the panel is redrawn after the other pending panels.
- Simultaneous Go on all panels with rr_ptr=0 gives service order 0,1,2.
- Reset mid-job aborts immediately to the reset state: writeEn=0 the next cycle and no DrawDone.
- Width rules:
  - X0 is computed in 8 bits; X0+16 must be at most 159 (checked by the bench, not the RTL).
  - y always stays in 21..51.

Optional Feature:
- Macro: VGA_SCHED_CLEAR_EN.
- Defined:
  - After reset, the FSM enters CLEAR before IDLE.
  - CLEAR writes OFF_COLOUR to all 160x120 pixels, row-major from (0,0) to (159,119): 19200 writeEn cycles with Busy=1.
  - CLEAR then sets pending=3'b111, so all three panels redraw.
  - Go during CLEAR sets pending normally, with no loss.
- Undefined: CLEAR does not exist; after reset the FSM sits in IDLE with pending=0.

Test Plan:
- Reset, VolumeOn=1, volume_data=7'd64, pulse VolumeGo:
  - writeEn high 135 cycles starting 2 cycles after the pulse.
  - First pixel (25,21,9d5), box last (41,27).
  - Bar y=51..44 colour a35, y=43..36 colour 000.
  - DrawDone=3'b001 once.
- PitchOn=0, pitch_data=0, PitchGo: box at x=65..81 all 000, 16 bar pixels at x=73 all 000, DrawDone[1] pulses.
- All three Go in the same cycle after reset: jobs in order 0,1,2, 2-cycle gaps, DrawDone bits pulse in sequence; repeat with rr_ptr=1, expect order 1,2,0.
- Change volume_data 127→0 and VolumeOn 1→0 mid-BOX: the current job keeps the snapshot colours and a full 15-pixel bar; a VolumeGo during the job triggers a second job with the new values.
- Assert Reset=0 at the 50th pixel: writeEn, Busy and DrawDone are 0 next cycle, and no further writes occur without a new Go.
- With VGA_SCHED_CLEAR_EN:
  - Release reset: 19200 black writes, last (159,119), then 3 panel jobs.
  - A DistortionGo issued during CLEAR is served once, merged with the auto-pending bit.
